// File: rtl/usart_rx_buffer_pkg.sv
// usart_rx_buffer_pkg: shared USART receive-buffer types and constants
package usart_rx_buffer_pkg;
  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} rx_state_e;
  localparam int ENTRY_W = 9;
  localparam int DEFAULT_DEPTH_LOG2 = 4;
endpackage

// File: rtl/usart_rx_buffer_if.sv
// usart_rx_buffer_if: receiver handshake plus bus-side read/status signals
interface usart_rx_buffer_if #(parameter int DEPTH_LOG2 = usart_rx_buffer_pkg::DEFAULT_DEPTH_LOG2) ();
  logic [7:0] rx_data;
  logic rx_available;
  logic rx_error;
  logic rx_acknowledge;
  logic rd_pop;
  logic [7:0] rd_data;
  logic rd_frame_error;
  logic empty;
  logic full;
  logic [DEPTH_LOG2:0] count;
  logic overrun;
  logic clear_overrun;
  modport master (
    output rx_data, rx_available, rx_error, rd_pop, clear_overrun,
    input rx_acknowledge, rd_data, rd_frame_error, empty, full, count, overrun
  );
  modport slave (
    input rx_data, rx_available, rx_error, rd_pop, clear_overrun,
    output rx_acknowledge, rd_data, rd_frame_error, empty, full, count, overrun
  );
endinterface

// File: rtl/usart_fifo.sv
// usart_fifo: show-ahead circular FIFO; push while full only lands if a pop frees the slot
module usart_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic do_push, do_pop;
  assign empty = count_q == '0;
  assign full = count_q[DEPTH_LOG2];
  assign count = count_q;
  assign head = empty ? '0 : mem_q[rd_ptr_q];
  always_comb begin
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{(DEPTH_LOG2-1){1'b0}}, do_pop};
    count_d = count_q + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/usart_rx_buffer.sv
// usart_rx_buffer: captures receiver frames via ack handshake into a FIFO with sticky overrun
module usart_rx_buffer
  import usart_rx_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input logic comm_clock,
  input logic reset,
  usart_rx_buffer_if.slave bus
);
  rx_state_e state_q, state_d;
  logic overrun_q, overrun_d;
  logic flag, push;
  logic [ENTRY_W-1:0] head;
  // one push per frame: capture only on the IDLE->ACK transition
  always_comb begin
    flag = bus.rx_available | bus.rx_error;
    push = (state_q == IDLE) & flag;
    state_d = flag ? ACK : IDLE;
    overrun_d = (push & bus.full & ~bus.rd_pop) | (overrun_q & ~bus.clear_overrun);
  end
  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      overrun_q <= overrun_d;
    end
  end
  usart_fifo #(.WIDTH(ENTRY_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk(comm_clock),
    .rst(reset),
    .push(push),
    .wdata({bus.rx_error, bus.rx_data}),
    .pop(bus.rd_pop),
    .head(head),
    .count(bus.count),
    .full(bus.full),
    .empty(bus.empty)
  );
  assign bus.rx_acknowledge = state_q == ACK;
  assign bus.overrun = overrun_q;
  assign bus.rd_data = head[7:0];
  assign bus.rd_frame_error = head[8];
endmodule

// File: tb/tb_usart_rx_buffer.sv
// tb_usart_rx_buffer: directed self-checking bench for usart_rx_buffer
module tb_usart_rx_buffer;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int passed = 0;
  usart_rx_buffer_if #(.DEPTH_LOG2(4)) u_if ();
  usart_rx_buffer #(.DEPTH_LOG2(4)) dut (.comm_clock(clk), .reset(rst), .bus(u_if));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic err);
    u_if.rx_data = d;
    u_if.rx_available = ~err;
    u_if.rx_error = err;
    tick();
    chk("send_ack_hi", u_if.rx_acknowledge, 1);
    u_if.rx_available = 0;
    u_if.rx_error = 0;
    tick();
    chk("send_ack_lo", u_if.rx_acknowledge, 0);
  endtask
  task automatic pop();
    u_if.rd_pop = 1;
    tick();
    u_if.rd_pop = 0;
  endtask
  initial begin
    rst = 1;
    u_if.rx_data = 0;
    u_if.rx_available = 0;
    u_if.rx_error = 0;
    u_if.rd_pop = 0;
    u_if.clear_overrun = 0;
    tick();
    tick();
    chk("rst_ack", u_if.rx_acknowledge, 0);
    chk("rst_empty", u_if.empty, 1);
    chk("rst_full", u_if.full, 0);
    chk("rst_count", u_if.count, 0);
    chk("rst_overrun", u_if.overrun, 0);
    chk("rst_rd_data", u_if.rd_data, 0);
    chk("rst_fe", u_if.rd_frame_error, 0);
    rst = 0;
    tick();
    // single frame, flag held 5 cycles
    u_if.rx_data = 8'h41;
    u_if.rx_available = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ack", u_if.rx_acknowledge, 1);
      chk("hold_count", u_if.count, 1);
    end
    u_if.rx_available = 0;
    tick();
    chk("drop_ack", u_if.rx_acknowledge, 0);
    chk("single_data", u_if.rd_data, 8'h41);
    chk("single_fe", u_if.rd_frame_error, 0);
    chk("single_count", u_if.count, 1);
    pop();
    chk("single_empty", u_if.empty, 1);
    chk("single_rd_zero", u_if.rd_data, 0);
    // framing error
    send(8'h7F, 1);
    chk("fe_flag", u_if.rd_frame_error, 1);
    chk("fe_data", u_if.rd_data, 8'h7F);
    pop();
    // fill and overrun, pointers start at 2 so reads wrap
    for (int i = 0; i < 16; i++) send(8'(i), 0);
    chk("fill_full", u_if.full, 1);
    chk("fill_count", u_if.count, 16);
    chk("fill_ovr0", u_if.overrun, 0);
    send(8'hAA, 0);
    chk("ovr_set", u_if.overrun, 1);
    chk("ovr_count", u_if.count, 16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", u_if.rd_data, i);
      pop();
    end
    chk("drain_empty", u_if.empty, 1);
    chk("drain_ovr_sticky", u_if.overrun, 1);
    u_if.clear_overrun = 1;
    tick();
    u_if.clear_overrun = 0;
    chk("ovr_clear", u_if.overrun, 0);
    // simultaneous push and pop while full
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 0);
    u_if.rx_data = 8'h55;
    u_if.rx_available = 1;
    u_if.rd_pop = 1;
    tick();
    u_if.rd_pop = 0;
    u_if.rx_available = 0;
    tick();
    chk("pp_count", u_if.count, 16);
    chk("pp_ovr", u_if.overrun, 0);
    for (int i = 1; i < 16; i++) begin
      chk("pp_data", u_if.rd_data, 8'h10 + i);
      pop();
    end
    chk("pp_last", u_if.rd_data, 8'h55);
    pop();
    chk("pp_empty", u_if.empty, 1);
    // pop on empty
    pop();
    chk("pe_count", u_if.count, 0);
    chk("pe_empty", u_if.empty, 1);
    send(8'h33, 0);
    chk("pe_data", u_if.rd_data, 8'h33);
    chk("pe_count1", u_if.count, 1);
    pop();
    // reset mid-ACK
    u_if.rx_data = 8'h66;
    u_if.rx_available = 1;
    tick();
    chk("rm_ack", u_if.rx_acknowledge, 1);
    chk("rm_count", u_if.count, 1);
    #2 rst = 1;
    #1;
    chk("rm_async_ack", u_if.rx_acknowledge, 0);
    chk("rm_async_count", u_if.count, 0);
    tick();
    rst = 0;
    tick();
    chk("rm_recap_ack", u_if.rx_acknowledge, 1);
    chk("rm_recap_count", u_if.count, 1);
    tick();
    tick();
    chk("rm_no_dup", u_if.count, 1);
    u_if.rx_available = 0;
    tick();
    chk("rm_ack_lo", u_if.rx_acknowledge, 0);
    chk("rm_data", u_if.rd_data, 8'h66);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/usart_rx_buffer.md
# usart_rx_buffer

Receive-side buffer that sits directly downstream of the USART receiver in the comm clock domain. It captures each completed frame (data byte plus framing-error flag) through the receiver's available/error/acknowledge handshake and queues it in a circular FIFO. It presents the frames to the bus-side register logic as a show-ahead queue with a pop strobe, plus occupancy and sticky overrun status.

## Interface
- DEPTH_LOG2, 4: log2 of FIFO depth (16 entries)
- comm_clock  in  1  sole clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rx_data  in  8  receiver byte; valid while rx_available or rx_error is high
- rx_available  in  1  receiver: good frame ready
- rx_error  in  1  receiver: frame with bad stop bit ready
- rx_acknowledge  out  1  level handshake back to receiver
- rd_pop  in  1  consume head entry
- rd_data  out  8  head byte (show-ahead)
- rd_frame_error  out  1  head entry's framing-error flag
- empty  out  1  no entries
- full  out  1  2^DEPTH_LOG2 entries
- count  out  DEPTH_LOG2+1  occupancy
- overrun  out  1  sticky: a frame was dropped because FIFO full
- clear_overrun  in  1  clears overrun

## Operation
- Reset values: rx_acknowledge 0, rd_data 0, rd_frame_error 0, empty 1, full 0, count 0, overrun 0, state IDLE, pointers 0.
- Handshake FSM, two states:
  - IDLE: if rx_available | rx_error: push {rx_error, rx_data}, set rx_acknowledge 1, go ACK. If both are high, rx_error wins the flag.
  - ACK: hold rx_acknowledge 1 until rx_available == 0 and rx_error == 0, then drive rx_acknowledge 0 and go IDLE. No capture in ACK.
- Exactly one push per frame; a flag held high across many cycles never produces duplicates.
- Push when full and no simultaneous pop: entry discarded, overrun set to 1, handshake completes normally so the receiver is not stalled.
- Push and pop in the same cycle:
  - Not empty: both performed, count unchanged. This includes the full case, where no overrun occurs.
  - Empty: pop ignored, push performed.
- Pop when empty: ignored; pointers and count unchanged.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. count is an explicit counter saturating in 0..2^DEPTH_LOG2.
- Status outputs:
  - full = (count == 2^DEPTH_LOG2); empty = (count == 0).
  - rd_data and rd_frame_error show the head entry whenever not empty, and 0 when empty.
- overrun: set by a dropped push, cleared by clear_overrun. If both occur in the same cycle, set wins.
- Reset mid-handshake: FSM returns to IDLE and rx_acknowledge drops immediately (asynchronously). Any frame still flagged after reset is captured as new.

## Timing
- Capture: flag seen high at edge N → entry written at edge N. It is visible on rd_data/count after edge N (cycle N+1). rx_acknowledge is high from cycle N+1.
- Acknowledge release: flags seen low at edge M in ACK → rx_acknowledge low from cycle M+1. Next capture is possible at edge M+1 at the earliest.
- Pop: rd_pop at edge N → head advances, count decrements, visible in cycle N+1.
- All outputs are registered or derived from registered state. There is no combinational path from rd_pop or rx_* to any output.

## Structure
- Shared USART package holds:
  - FSM state constants: IDLE = 1'b0, ACK = 1'b1.
  - Entry width: 9 = {frame_error, data[7:0]}.
  - Default DEPTH_LOG2.
- One sub-module, usart_fifo: a generic synchronous circular FIFO (parameters WIDTH and DEPTH_LOG2). It has push, pop, head, count, full and empty, and implements the simultaneous push/pop rules above. usart_rx_buffer contains the handshake FSM and overrun logic around it.

## Test plan
- Single frame: rx_data 0x41, rx_available held 5 cycles then dropped.
  - Required: one push; rx_acknowledge high from the capture cycle +1 until 1 cycle after the drop.
  - Then rd_data 0x41, rd_frame_error 0, count 1; rd_pop → empty 1, rd_data 0.
- Framing error: rx_error with rx_data 0x7F → rd_frame_error 1, rd_data 0x7F.
- Fill and overrun:
  - 16 frames 0x00..0x0F → full 1, count 16.
  - 17th frame 0xAA → still acknowledged, overrun 1, data dropped.
  - Pops return 0x00..0x0F in order, including correct pointer wrap.
  - clear_overrun → overrun 0.
- Simultaneous push and pop while full: frame 0x55 captured in the same cycle as rd_pop → count stays 16, no overrun, 0x55 appears last.
- Pop on empty: rd_pop with count 0 → count stays 0, no pointer movement; a following frame reads back correctly.
- Reset mid-ACK: assert reset while rx_acknowledge is high and rx_available is high.
  - Required: rx_acknowledge 0, count 0 immediately.
  - After reset release with rx_available still high: exactly one new capture.
